bk_add_arbiter: RTL and testbench

- Shares one 32-bit Brent-Kung adder core among NREQ requesters.
- Each requester has its own valid/ready request channel. Grants are round-robin.
- Results are returned on a single registered response channel tagged with the requester ID.
- Each requester has a carry register, so multi-word (multiprecision) adds can be chained across successive requests from the same client.

---
 rtl/bk_add_arbiter_pkg.sv | 21 ++
 rtl/bk_add_arbiter_core.sv | 49 ++++
 rtl/bk_add_arbiter_rr_pick.sv | 30 +++
 rtl/bk_add_arbiter.sv | 118 +++++++++++
 tb/tb_bk_add_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/bk_add_arbiter_pkg.sv
// Shared constants and types for the Brent-Kung adder arbiter.
package bk_add_arbiter_pkg;

    localparam int ADD_W    = 32;
    localparam int ADD_NREQ = 4;
    localparam int ADD_IDW  = $clog2(ADD_NREQ);

    // Output register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Response field ordering: {id, cout, sum}.
    typedef struct packed {
        logic [ADD_IDW-1:0] id;
        logic               cout;
        logic [ADD_W-1:0]   sum;
    } rsp_t;

endpackage

// File: rtl/bk_add_arbiter_core.sv
// Combinational Brent-Kung parallel-prefix adder, N-bit operands, N+1-bit result.
module bk_add_core #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N:0]   sum
);

    localparam int LOG = $clog2(N);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] gg;
    logic [N-1:0] pp;

    // Carry-in folds into bit 0's generate so every prefix gg[i] is the carry out of bit i.
    // Up-sweep builds power-of-two spans; down-sweep fills the remaining positions.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        gg    = g;
        pp    = p;
        gg[0] = g[0] | (p[0] & cin);
        for (int l = 0; (1 << l) < N; l++) begin
            for (int i = 0; i < N; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                    pp[i] = pp[i] & pp[i - (1 << l)];
                end
            end
        end
        for (int l = LOG - 2; l >= 0; l--) begin
            for (int i = 0; i < N; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                    pp[i] = pp[i] & pp[i - (1 << l)];
                end
            end
        end
        sum[0] = p[0] ^ cin;
        for (int i = 1; i < N; i++) begin
            sum[i] = p[i] ^ gg[i - 1];
        end
        sum[N] = gg[N-1];
    end

endmodule

// File: rtl/bk_add_arbiter_rr_pick.sv
// Rotate-priority picker: first set request at or above ptr (wrapping) wins.
module rr_pick_onehot #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    // Scan from ptr upward modulo NREQ, latching the first hit.
    always_comb begin
        int   j;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/bk_add_arbiter.sv
// Round-robin arbiter sharing one Brent-Kung adder among NREQ clients,
// with per-client carry registers for multiprecision chaining.
module bk_add_arbiter
    import bk_add_arbiter_pkg::*;
#(
    parameter int N    = ADD_W,
    parameter int NREQ = ADD_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_chain,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_sum,
    output logic              rsp_cout
);

    state_e          state_q,    state_d;
    logic [IDW-1:0]  ptr_q,      ptr_d;
    logic [NREQ-1:0] carry_q,    carry_d;
    logic [IDW-1:0]  rsp_id_q,   rsp_id_d;
    logic [N-1:0]    rsp_sum_q,  rsp_sum_d;
    logic            rsp_cout_q, rsp_cout_d;

    logic [NREQ-1:0] grant_oh;
    logic [IDW-1:0]  grant_idx;
    logic            can_accept;
    logic            accept;
    logic [N-1:0]    add_a;
    logic [N-1:0]    add_b;
    logic            add_cin;
    logic [N:0]      add_sum;

    rr_pick_onehot #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant_oh),
        .idx   (grant_idx)
    );

    bk_add_core #(
        .N (N)
    ) u_add (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum)
    );

    // Handshake and operand select: only the winner's operands reach the adder.
    always_comb begin
        can_accept = !rst && ((state_q == ST_EMPTY) || rsp_ready);
        req_ready  = grant_oh & {NREQ{can_accept}};
        accept     = |req_ready;
        add_a      = req_a[grant_idx*N +: N];
        add_b      = req_b[grant_idx*N +: N];
        add_cin    = req_chain[grant_idx] ? carry_q[grant_idx] : req_cin[grant_idx];
    end

    // Next-state: accept loads a new response, drain alone empties, otherwise hold.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        carry_d    = carry_q;
        rsp_id_d   = rsp_id_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        if (accept) begin
            state_d             = ST_FULL;
            rsp_id_d            = grant_idx;
            rsp_sum_d           = add_sum[N-1:0];
            rsp_cout_d          = add_sum[N];
            carry_d[grant_idx]  = add_sum[N];
            if (int'(grant_idx) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            ptr_q      <= '0;
            carry_q    <= '0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            carry_q    <= carry_d;
            rsp_id_q   <= rsp_id_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_bk_add_arbiter.sv
// Directed bench for bk_add_arbiter: vector table plus multi-cycle sequences.
module tb_bk_add_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_chain;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_sum;
    logic              rsp_cout;

    int total;
    int bad;

    bk_add_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          client;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        chain;
        logic [31:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_chain = '0;
    endtask

    task automatic set_req(input int c, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic chain);
        req_valid[c]     = 1'b1;
        req_a[c*N +: N]  = a;
        req_b[c*N +: N]  = b;
        req_cin[c]       = cin;
        req_chain[c]     = chain;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0]  exp_oh;
    logic [31:0] held_sum;

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        clear_reqs();

        // Reset state, with requests asserted during reset.
        req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_id",    64'(rsp_id),    64'h0);
        check("rst_rsp_sum",   64'(rsp_sum),   64'h0);
        check("rst_rsp_cout",  64'(rsp_cout),  64'h0);
        clear_reqs();
        rst = 1'b0;

        // client, a, b, cin, chain, sum, cout (carry state carries across rows)
        vecs[0]  = '{2, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_000D, 1'b0};
        vecs[1]  = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
        vecs[2]  = '{0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0};
        vecs[3]  = '{1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
        vecs[4]  = '{3, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0};
        vecs[6]  = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{3, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 32'h1234_5679, 1'b0};
        vecs[8]  = '{2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0};
        vecs[9]  = '{2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[10] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1};
        vecs[11] = '{1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0};

        // Table: one client at a time, response checked the cycle after accept.
        @(negedge clk);
        for (int v = 0; v < 12; v++) begin
            clear_reqs();
            set_req(vecs[v].client, vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].chain);
            #1;
            exp_oh = 4'b0001 << vecs[v].client;
            check($sformatf("v%0d_ready", v), 64'(req_ready), 64'(exp_oh));
            @(negedge clk);
            clear_reqs();
            check($sformatf("v%0d_valid", v), 64'(rsp_valid), 64'h1);
            check($sformatf("v%0d_id", v),    64'(rsp_id),    64'(vecs[v].client));
            check($sformatf("v%0d_sum", v),   64'(rsp_sum),   64'(vecs[v].exp_sum));
            check($sformatf("v%0d_cout", v),  64'(rsp_cout),  64'(vecs[v].exp_cout));
        end

        // Drain with nothing to accept empties the output register.
        @(negedge clk);
        check("drain_valid", 64'(rsp_valid), 64'h0);

        // Round robin from pointer 0 with all four clients requesting.
        do_reset();
        for (int c = 0; c < NREQ; c++) begin
            set_req(c, 32'(c * 16), 32'h1, 1'b0, 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_oh = 4'b0001 << (k % NREQ);
            check($sformatf("rr%0d_ready", k), 64'(req_ready), 64'(exp_oh));
            @(negedge clk);
            check($sformatf("rr%0d_id", k),  64'(rsp_id),  64'(k % NREQ));
            check($sformatf("rr%0d_sum", k), 64'(rsp_sum), 64'((k % NREQ) * 16 + 1));
        end
        clear_reqs();

        // Backpressure: client 3 fills, consumer stalls 3 cycles while 1 and 3 wait.
        do_reset();
        set_req(3, 32'd10, 32'd20, 1'b0, 1'b0);
        @(negedge clk);
        clear_reqs();
        rsp_ready = 1'b0;
        set_req(1, 32'd1, 32'd2, 1'b0, 1'b0);
        set_req(3, 32'd5, 32'd5, 1'b0, 1'b0);
        held_sum = 32'd30;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d_ready", k), 64'(req_ready), 64'h0);
            check($sformatf("bp%0d_valid", k), 64'(rsp_valid), 64'h1);
            check($sformatf("bp%0d_id", k),    64'(rsp_id),    64'h3);
            check($sformatf("bp%0d_sum", k),   64'(rsp_sum),   64'(held_sum));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_ready), 64'h2);
        @(negedge clk);
        check("bp_release_id",  64'(rsp_id),  64'h1);
        check("bp_release_sum", 64'(rsp_sum), 64'h3);
        clear_reqs();

        // Reset while FULL with id=1 and a live carry in client 1.
        do_reset();
        set_req(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        @(negedge clk);
        clear_reqs();
        check("mr_full_id",   64'(rsp_id),   64'h1);
        check("mr_full_cout", 64'(rsp_cout), 64'h1);
        rsp_ready = 1'b0;
        rst = 1'b1;
        set_req(1, 32'h0, 32'h0, 1'b0, 1'b1);
        #1;
        check("mr_rst_ready", 64'(req_ready), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        check("mr_valid", 64'(rsp_valid), 64'h0);
        set_req(3, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check("mr_ptr_ready", 64'(req_ready), 64'h2);
        @(negedge clk);
        check("mr_chain_id",   64'(rsp_id),   64'h1);
        check("mr_chain_sum",  64'(rsp_sum),  64'h0);
        check("mr_chain_cout", 64'(rsp_cout), 64'h0);
        clear_reqs();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
